// File: rtl/replica_pkg.sv
// Shared replica-chain data types plus the readout bank index type.
// Imported by the bank readout sequencer, its FIFO and its bus interface.
package replica_pkg;

    typedef logic [15:0] replica_data_t;
    typedef logic [31:0] total_data_t;

    localparam int unsigned bank_num_max = 8;
    typedef logic [$clog2(bank_num_max)-1:0] readout_bank_t;

    // Counter width that never collapses to zero bits for a modulus of 1.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bank_readout_seq_if.sv
// Host-side readback port of the bank readout sequencer: ordering stream
// (ready/valid) and the distance word with its consume strobe.
interface bank_readout_seq_if;
    import replica_pkg::*;

    logic          ord_rd_valid;
    replica_data_t ord_rd_data;
    logic          ord_rd_ready;
    logic          dis_shift;
    total_data_t   dis_rdata;

    modport master (
        output ord_rd_valid,
        output ord_rd_data,
        output dis_rdata,
        input  ord_rd_ready,
        input  dis_shift
    );

    modport slave (
        input  ord_rd_valid,
        input  ord_rd_data,
        input  dis_rdata,
        output ord_rd_ready,
        output dis_shift
    );

endinterface

// File: rtl/readout_fifo.sv
// Generic synchronous FIFO for ordering words; head is read combinationally
// from storage so it stays stable until popped. DEPTH must be a power of 2.
module readout_fifo
    import replica_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_flush,
    input  logic          i_push,
    input  replica_data_t i_push_data,
    input  logic          i_pop,
    output replica_data_t o_head,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);

    replica_data_t r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bank_readout_seq.sv
// Sequences host readback of ordering words and total distances from the
// replica-chain tails, bank by bank. READOUT_ERR_EN enables the sticky rd_err checker.
module bank_readout_seq
    import replica_pkg::*;
#(
    parameter  int bank_num   = 2,
    parameter  int ord_words  = 4,
    parameter  int fifo_depth = 4,
    localparam int BW         = $clog2(bank_num),
    localparam int CW         = clog2_min1(ord_words),
    localparam int AW         = $clog2(fifo_depth)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clear,
    input  logic                i_run_busy,
    input  logic [bank_num-1:0] i_bank_ord_valid,
    input  replica_data_t       i_bank_ord_data [bank_num],
    output logic [bank_num-1:0] o_bank_ord_shift,
    input  total_data_t         i_bank_dis_data [bank_num],
    output logic [BW-1:0]       o_rd_bank,
    output logic                o_rd_err,
    bank_readout_seq_if.master  bus
);

    localparam logic [BW-1:0] BANK_LAST = BW'(bank_num - 1);
    localparam logic [CW-1:0] WORD_LAST = CW'(ord_words - 1);

    logic [BW-1:0] r_rd_bank;
    logic [BW-1:0] r_dis_sel;
    logic [CW-1:0] r_word_cnt;
    logic [AW:0]   w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_fetch;
    logic          w_pop;

    function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
        return (b == BANK_LAST) ? '0 : b + BW'(1);
    endfunction

    // Reset is included so a held reset never pops a chain.
    assign w_fetch = !reset && !i_clear && !i_run_busy
                     && i_bank_ord_valid[r_rd_bank] && !w_full;
    assign w_pop   = bus.ord_rd_ready && !w_empty;

    always_comb begin
        o_bank_ord_shift = '0;
        if (w_fetch) begin
            o_bank_ord_shift[r_rd_bank] = 1'b1;
        end
    end

    readout_fifo #(
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (i_clear),
        .i_push      (w_fetch),
        .i_push_data (i_bank_ord_data[r_rd_bank]),
        .i_pop       (w_pop),
        .o_head      (bus.ord_rd_data),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign bus.ord_rd_valid = (w_count != '0);

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_rd_bank  <= '0;
            r_word_cnt <= '0;
            r_dis_sel  <= '0;
        end else begin
            if (w_fetch) begin
                if (r_word_cnt == WORD_LAST) begin
                    r_word_cnt <= '0;
                    r_rd_bank  <= next_bank(r_rd_bank);
                end else begin
                    r_word_cnt <= r_word_cnt + CW'(1);
                end
            end
            if (bus.dis_shift) begin
                r_dis_sel <= next_bank(r_dis_sel);
            end
        end
    end

    assign o_rd_bank     = r_rd_bank;
    assign bus.dis_rdata = i_bank_dis_data[r_dis_sel];

`ifdef READOUT_ERR_EN
    logic r_rd_err;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_rd_err <= 1'b0;
        end else if ((bus.ord_rd_ready && w_empty) || (bus.dis_shift && i_run_busy)) begin
            r_rd_err <= 1'b1;
        end
    end

    assign o_rd_err = r_rd_err;
`else
    assign o_rd_err = 1'b0;
`endif

endmodule
